pc060ha_mailbox_arbiter: RTL
============================

// Module: pc060ha_mailbox_arbiter
// PURPOSE
//  Shared-mailbox controller of the PC060HA sound-comm chip. Serialises main-CPU and sub-CPU accesses
//  to the nibble mailbox (4x4b main->sub, 4x4b sub->main), keeps full flags, drives sub NMI/reset.
//  Each side addresses through its own page register (PAGE inputs); this block sequences the accesses.
// PARAMETERS
//  SYNC_STAGES  2  flops per strobe synchroniser (>=2)
//  DW           4  mailbox data width
// PORTS
//  CLK          in   1   master clock; all state on posedge
//  nRESET       in   1   async active-low reset
//  M_nCS/M_nRD/M_nWR  in 1 each  main-side bus strobes, async to CLK
//  M_PAGE       in   3   main-side page register value
//  M_DIN        in   DW  main write data
//  M_DOUT       out  DW  main read data, held until next main read
//  S_nCS/S_nRD/S_nWR  in 1 each  sub-side bus strobes, async to CLK
//  S_PAGE       in   3   sub-side page register value
//  S_DIN        in   DW  sub write data
//  S_DOUT       out  DW  sub read data, held until next sub read
//  nNMI         out  1   sub-CPU NMI, level, active-low
//  SUB_nRESET   out  1   sub-CPU reset request, active-low
// BEHAVIOUR
//  Reset: M_DOUT=S_DOUT=0, all mailbox nibbles 0, M2S_FULL=S2M_FULL=0, nmi_en=0, nNMI=1, SUB_nRESET=0
//   (sub held in reset until main releases it), rr pointer favours main.
//  Request capture (per side): act = ~nCS & (~nRD | ~nWR) synchronised SYNC_STAGES deep; rising edge of
//   synced act latches {is_wr, PAGE, DIN} into pending slot. PAGE/DIN/strobe type sampled at that cycle;
//   CPU holds them stable for the whole strobe. New edge while slot pending: dropped (cannot occur at spec'd rates).
//  Arbiter: one grant per CLK. One pending -> grant it. Both pending same cycle -> rr pointer side wins,
//   pointer flips to the other side. Grant executes in the grant cycle; pending slot clears same edge.
//  Latency: strobe assert -> DOUT valid <= SYNC_STAGES+3 CLK (incl. one lost arbitration). CPU RD must
//   exceed this.
//  Main page map: wr 0-3 -> m2s[p]; wr 3 also sets M2S_FULL. rd 0-3 <- s2m[p]; rd 3 also clears S2M_FULL.
//   rd 4 <- {0,0,S2M_FULL,M2S_FULL}. wr 4: SUB_nRESET <= DIN[0]. others: rd 0, wr ignored.
//  Sub page map: wr 0-3 -> s2m[p]; wr 3 also sets S2M_FULL. rd 0-3 <- m2s[p]; rd 3 also clears M2S_FULL.
//   rd 4 <- {0,0,M2S_FULL,S2M_FULL}. wr 5: nmi_en<=1. wr 6: nmi_en<=0. others: rd 0, wr ignored.
//  nNMI = ~(M2S_FULL & nmi_en), registered (1 CLK after flag/enable change).
//  Flag set/clear only via granted accesses, so same-cycle set vs clear impossible; order = grant order.
//  Write page 3 while already full: data overwritten, flag stays 1 (no overrun flag).
//  SUB_nRESET low: sub-side requests still arbitrated (bus inactive anyway); nmi_en forced 0.
//  nRESET assert mid-access: all state to reset values immediately; pending slots cleared; synchronisers
//   cleared so a strobe held across reset release does not generate a request.
// STRUCTURE
//  Package pc060ha_pkg: page constants (PG_DATA0..PG_DATA3, PG_STATUS=4, PG_NMI_EN=5, PG_NMI_DIS=6),
//   side enum SIDE_MAIN/SIDE_SUB, request struct {is_wr, page, data}.
//  Sub-module pc060ha_strobe_sync (synchroniser + edge detect + pending slot), instantiated per side.
//  Top: arbiter, mailbox regs, flags, nmi_en, SUB_nRESET, DOUT holds.
// TESTING
//  Reset, main wr p4 DIN=1 -> SUB_nRESET 0->1; main rd p4 -> M_DOUT=0000.
//  Main wr p0..p3=A,B,C,D, sub wr p5 -> M2S_FULL=1, nNMI low 1 CLK later; sub rd p0..p3 -> A,B,C,D,
//   after p3 read M2S_FULL=0, nNMI high.
//  Sub wr p0..p3=1,2,3,4 -> main rd p4=0010; main rd p3=4 -> S2M_FULL=0, rd p4=0000.
//  Both sides strobe same CLK (main wr p3=5, sub rd p3) x2 -> grants alternate M,S then S,M;
//   final M2S_FULL matches last granted op; DOUT per side within SYNC_STAGES+3 CLK.
//  nmi_en=0 with M2S_FULL=1 -> nNMI stays 1; sub wr p5 -> nNMI=0; sub wr p6 -> nNMI=1.
//  nRESET pulsed mid main write strobe -> no mailbox change, flags 0, no request after release.

Source files
------------

// File: rtl/pc060ha_pkg.sv
// Shared types and page map for the PC060HA sound-comm mailbox.
package pc060ha_pkg;

    localparam int PW       = 3;
    localparam int MB_DW    = 4;
    localparam int MB_DEPTH = 4;

    localparam logic [PW-1:0] PG_DATA0   = 3'd0;
    localparam logic [PW-1:0] PG_DATA1   = 3'd1;
    localparam logic [PW-1:0] PG_DATA2   = 3'd2;
    localparam logic [PW-1:0] PG_DATA3   = 3'd3;
    localparam logic [PW-1:0] PG_STATUS  = 3'd4;
    localparam logic [PW-1:0] PG_SUBRST  = 3'd4;
    localparam logic [PW-1:0] PG_NMI_EN  = 3'd5;
    localparam logic [PW-1:0] PG_NMI_DIS = 3'd6;

    typedef enum logic {
        SIDE_MAIN = 1'b0,
        SIDE_SUB  = 1'b1
    } side_e;

    typedef struct packed {
        logic             is_wr;
        logic [PW-1:0]    page;
        logic [MB_DW-1:0] data;
    } req_t;

    function automatic logic is_data_page(input logic [PW-1:0] p);
        return (p <= PG_DATA3);
    endfunction

    // Status nibble: the caller's own "incoming full" flag sits in bit 1.
    function automatic logic [MB_DW-1:0] status_word(input logic rx_full, input logic tx_full);
        return {2'b00, rx_full, tx_full};
    endfunction

endpackage

// File: rtl/pc060ha_strobe_sync.sv
// Bus strobe synchroniser, rising-edge detect and single pending request slot.
module pc060ha_strobe_sync
    import pc060ha_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ncs_i,
    input  logic             nrd_i,
    input  logic             nwr_i,
    input  logic [PW-1:0]    page_i,
    input  logic [MB_DW-1:0] din_i,
    input  logic             grant_i,
    output logic             pend_o,
    output req_t             req_o
);

    logic                   act;
    logic                   rise;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pend_q, pend_d;
    req_t                   req_q, req_d;

    assign act  = ~ncs_i & (~nrd_i | ~nwr_i);
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Chain resets to "active" so a strobe held across reset release is not seen as a new edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            pend_q <= 1'b0;
            req_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], act};
            prev_q <= sync_q[SYNC_STAGES-1];
            pend_q <= pend_d;
            req_q  <= req_d;
        end
    end

    always_comb begin
        pend_d = pend_q;
        req_d  = req_q;
        if (grant_i) begin
            pend_d = 1'b0;
        end else if (rise && !pend_q) begin
            pend_d      = 1'b1;
            req_d.is_wr = ~nwr_i;
            req_d.page  = page_i;
            req_d.data  = din_i;
        end
    end

    assign pend_o = pend_q;
    assign req_o  = req_q;

endmodule

// File: rtl/pc060ha_mailbox_arbiter.sv
// PC060HA mailbox: round-robin arbitration of main/sub accesses to the nibble mailbox,
// full flags, sub NMI and sub reset control.
module pc060ha_mailbox_arbiter
    import pc060ha_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DW          = MB_DW
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          m_ncs_i,
    input  logic          m_nrd_i,
    input  logic          m_nwr_i,
    input  logic [PW-1:0] m_page_i,
    input  logic [DW-1:0] m_din_i,
    output logic [DW-1:0] m_dout_o,
    input  logic          s_ncs_i,
    input  logic          s_nrd_i,
    input  logic          s_nwr_i,
    input  logic [PW-1:0] s_page_i,
    input  logic [DW-1:0] s_din_i,
    output logic [DW-1:0] s_dout_o,
    output logic          nnmi_o,
    output logic          sub_nreset_o
);

    logic    m_pend, s_pend;
    req_t    m_req, s_req;
    logic    grant_m, grant_s;

    side_e   rr_q, rr_d;
    logic [DW-1:0] m2s_q [MB_DEPTH];
    logic [DW-1:0] m2s_d [MB_DEPTH];
    logic [DW-1:0] s2m_q [MB_DEPTH];
    logic [DW-1:0] s2m_d [MB_DEPTH];
    logic          m2s_full_q, m2s_full_d;
    logic          s2m_full_q, s2m_full_d;
    logic          nmi_en_q, nmi_en_d;
    logic          sub_nreset_q, sub_nreset_d;
    logic [DW-1:0] m_dout_q, m_dout_d;
    logic [DW-1:0] s_dout_q, s_dout_d;
    logic          nnmi_q;

    pc060ha_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_main (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ncs_i   (m_ncs_i),
        .nrd_i   (m_nrd_i),
        .nwr_i   (m_nwr_i),
        .page_i  (m_page_i),
        .din_i   (m_din_i),
        .grant_i (grant_m),
        .pend_o  (m_pend),
        .req_o   (m_req)
    );

    pc060ha_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_sub (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ncs_i   (s_ncs_i),
        .nrd_i   (s_nrd_i),
        .nwr_i   (s_nwr_i),
        .page_i  (s_page_i),
        .din_i   (s_din_i),
        .grant_i (grant_s),
        .pend_o  (s_pend),
        .req_o   (s_req)
    );

    // Pointer only moves on contention, so an idle side keeps its turn.
    always_comb begin
        grant_m = m_pend & (~s_pend | (rr_q == SIDE_MAIN));
        grant_s = s_pend & (~m_pend | (rr_q == SIDE_SUB));
        rr_d    = rr_q;
        if (m_pend && s_pend) begin
            rr_d = (rr_q == SIDE_MAIN) ? SIDE_SUB : SIDE_MAIN;
        end
    end

    always_comb begin
        m2s_d        = m2s_q;
        s2m_d        = s2m_q;
        m2s_full_d   = m2s_full_q;
        s2m_full_d   = s2m_full_q;
        nmi_en_d     = nmi_en_q;
        sub_nreset_d = sub_nreset_q;
        m_dout_d     = m_dout_q;
        s_dout_d     = s_dout_q;

        if (grant_m) begin
            if (m_req.is_wr) begin
                if (is_data_page(m_req.page)) begin
                    m2s_d[m_req.page[1:0]] = m_req.data;
                    if (m_req.page == PG_DATA3) begin
                        m2s_full_d = 1'b1;
                    end
                end else if (m_req.page == PG_SUBRST) begin
                    sub_nreset_d = m_req.data[0];
                end
            end else begin
                if (is_data_page(m_req.page)) begin
                    m_dout_d = s2m_q[m_req.page[1:0]];
                    if (m_req.page == PG_DATA3) begin
                        s2m_full_d = 1'b0;
                    end
                end else if (m_req.page == PG_STATUS) begin
                    m_dout_d = status_word(s2m_full_q, m2s_full_q);
                end else begin
                    m_dout_d = '0;
                end
            end
        end

        if (grant_s) begin
            if (s_req.is_wr) begin
                if (is_data_page(s_req.page)) begin
                    s2m_d[s_req.page[1:0]] = s_req.data;
                    if (s_req.page == PG_DATA3) begin
                        s2m_full_d = 1'b1;
                    end
                end else if (s_req.page == PG_NMI_EN) begin
                    nmi_en_d = 1'b1;
                end else if (s_req.page == PG_NMI_DIS) begin
                    nmi_en_d = 1'b0;
                end
            end else begin
                if (is_data_page(s_req.page)) begin
                    s_dout_d = m2s_q[s_req.page[1:0]];
                    if (s_req.page == PG_DATA3) begin
                        m2s_full_d = 1'b0;
                    end
                end else if (s_req.page == PG_STATUS) begin
                    s_dout_d = status_word(m2s_full_q, s2m_full_q);
                end else begin
                    s_dout_d = '0;
                end
            end
        end

        // A sub CPU held in reset cannot have NMI armed.
        if (!sub_nreset_q) begin
            nmi_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < MB_DEPTH; i++) begin
                m2s_q[i] <= '0;
                s2m_q[i] <= '0;
            end
            m2s_full_q   <= 1'b0;
            s2m_full_q   <= 1'b0;
            nmi_en_q     <= 1'b0;
            sub_nreset_q <= 1'b0;
            m_dout_q     <= '0;
            s_dout_q     <= '0;
            nnmi_q       <= 1'b1;
            rr_q         <= SIDE_MAIN;
        end else begin
            m2s_q        <= m2s_d;
            s2m_q        <= s2m_d;
            m2s_full_q   <= m2s_full_d;
            s2m_full_q   <= s2m_full_d;
            nmi_en_q     <= nmi_en_d;
            sub_nreset_q <= sub_nreset_d;
            m_dout_q     <= m_dout_d;
            s_dout_q     <= s_dout_d;
            nnmi_q       <= ~(m2s_full_q & nmi_en_q);
            rr_q         <= rr_d;
        end
    end

    assign m_dout_o     = m_dout_q;
    assign s_dout_o     = s_dout_q;
    assign nnmi_o       = nnmi_q;
    assign sub_nreset_o = sub_nreset_q;

endmodule
